// File: rtl/control_temp_pkg.sv
// Shared definitions for the temperature controller: state codes (also used by
// the 7-segment display logic) and a saturating subtraction helper.
package control_temp_pkg;

  localparam int unsigned ESTADO_W = 2;

  typedef enum logic [ESTADO_W-1:0] {
    NORMAL     = 2'd0,
    VENTILANDO = 2'd1,
    ALARMA     = 2'd2
  } estado_t;

  // a - b clamped at zero, so a threshold minus hysteresis never wraps
  function automatic int unsigned resta_sat(input int unsigned a, input int unsigned b);
    return (a > b) ? (a - b) : 32'd0;
  endfunction

endpackage

// File: rtl/contador_persistencia.sv
// Consecutive-sample counter: counts qualifying samples, clears on demand,
// saturates at N. lleno flags the sample that completes a run of N, so the
// caller can act on the same edge that sample is taken.
module contador_persistencia #(
  parameter int unsigned N = 3
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic inc,
  output logic lleno
);

  localparam int unsigned W_CNT = $clog2(N + 1);
  localparam logic [W_CNT-1:0] CNT_MAX  = W_CNT'(N);
  localparam logic [W_CNT-1:0] CNT_CASI = W_CNT'(N - 1);

  logic [W_CNT-1:0] r_cnt;

  // Count register; clear wins over increment, holds at N
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + W_CNT'(1);
    end
  end

  assign lleno = inc && (r_cnt >= CNT_CASI);

endmodule

// File: rtl/control_temp.sv
// Temperature controller: NORMAL / VENTILANDO / ALARMA with per-transition
// persistence filtering, hysteresis and a latched, acknowledged alarm.
// Optional sensor-silence watchdog enabled by defining SENSOR_TIMEOUT_EN;
// without it Falla_sensor is tied low.
module control_temp
  import control_temp_pkg::*;
#(
  parameter int unsigned       ANCHO         = 5,
  parameter logic [ANCHO-1:0]  UMBRAL_VENT   = 5'd20,
  parameter logic [ANCHO-1:0]  UMBRAL_ALARMA = 5'd28,
  parameter logic [ANCHO-1:0]  HIST          = 5'd2,
  parameter int unsigned       N_MUESTRAS    = 3,
  parameter logic [15:0]       TIMEOUT       = 16'd50000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [ANCHO-1:0] Temp,
  input  logic             Temp_valid,
  input  logic             Ack,
  output logic             Ventilacion,
  output logic             Alarma,
  output logic [1:0]       Estado,
  output logic             Falla_sensor
);

  localparam logic [ANCHO-1:0] VENT_BAJA =
    ANCHO'(resta_sat(32'(UMBRAL_VENT), 32'(HIST)));
  localparam logic [ANCHO-1:0] ALARMA_BAJA =
    ANCHO'(resta_sat(32'(UMBRAL_ALARMA), 32'(HIST)));

  estado_t          r_estado;
  estado_t          w_estado_sig;
  logic             r_vent;
  logic             r_alarma;
  logic [ANCHO-1:0] r_ultima;
  logic [ANCHO-1:0] w_ultima;
  logic             w_cambio;
  logic             w_inc_v, w_clr_v, w_lleno_v;
  logic             w_inc_a, w_clr_a, w_lleno_a;
  logic             w_timeout;
  logic             w_muestra_ok;
  logic             w_acepta;

  // Most recent valid sample, with a same-cycle strobe taking precedence
  assign w_ultima = Temp_valid ? Temp : r_ultima;

  // Fan counter tracks the direction relevant to the current state; the
  // alarm counter runs in both non-alarm states
  assign w_inc_v = Temp_valid &&
                   (((r_estado == NORMAL)     && (Temp >= UMBRAL_VENT)) ||
                    ((r_estado == VENTILANDO) && (Temp <  VENT_BAJA)));
  assign w_clr_v = w_cambio || (Temp_valid && !w_inc_v);
  assign w_inc_a = Temp_valid && (Temp >= UMBRAL_ALARMA) &&
                   ((r_estado == NORMAL) || (r_estado == VENTILANDO));
  assign w_clr_a = w_cambio || (Temp_valid && !w_inc_a);

  assign w_cambio = (w_estado_sig != r_estado);

  assign w_acepta = (r_estado == ALARMA) && Ack && (w_ultima < ALARMA_BAJA) &&
                    w_muestra_ok && !w_timeout;

  contador_persistencia #(.N(N_MUESTRAS)) u_cnt_vent (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (w_clr_v),
    .inc     (w_inc_v),
    .lleno   (w_lleno_v)
  );

  contador_persistencia #(.N(N_MUESTRAS)) u_cnt_alarma (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (w_clr_a),
    .inc     (w_inc_a),
    .lleno   (w_lleno_a)
  );

  // Last-sample register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ultima <= '0;
    end else if (Temp_valid) begin
      r_ultima <= Temp;
    end
  end

`ifdef SENSOR_TIMEOUT_EN
  logic [15:0] r_cnt_to;
  logic        r_falla;
  logic        r_muestra_nueva;

  // A strobe on the saturating cycle counts as sensor activity, not silence
  assign w_timeout    = (r_cnt_to == TIMEOUT) && !Temp_valid;
  assign w_muestra_ok = !r_falla || Temp_valid || r_muestra_nueva;
  assign Falla_sensor = r_falla;

  // Silence counter, fault flag and "sample seen since fault" flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt_to        <= '0;
      r_falla         <= 1'b0;
      r_muestra_nueva <= 1'b0;
    end else begin
      if (Temp_valid) begin
        r_cnt_to <= '0;
      end else if (r_cnt_to != TIMEOUT) begin
        r_cnt_to <= r_cnt_to + 16'd1;
      end
      if (Temp_valid) begin
        r_muestra_nueva <= 1'b1;
      end else if (w_timeout) begin
        r_muestra_nueva <= 1'b0;
      end
      if (w_timeout) begin
        r_falla <= 1'b1;
      end else if (w_acepta) begin
        r_falla <= 1'b0;
      end
    end
  end
`else
  logic w_unused_timeout;

  assign w_timeout        = 1'b0;
  assign w_muestra_ok     = 1'b1;
  assign Falla_sensor     = 1'b0;
  assign w_unused_timeout = ^TIMEOUT;
`endif

  // State and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_estado <= NORMAL;
      r_vent   <= 1'b0;
      r_alarma <= 1'b0;
    end else begin
      r_estado <= w_estado_sig;
      r_vent   <= (w_estado_sig == VENTILANDO);
      r_alarma <= (w_estado_sig == ALARMA);
    end
  end

  // Next-state logic; alarm has priority, illegal code recovers to NORMAL
  always_comb begin
    w_estado_sig = r_estado;
    case (r_estado)
      NORMAL: begin
        if (w_timeout || w_lleno_a) begin
          w_estado_sig = ALARMA;
        end else if (w_lleno_v) begin
          w_estado_sig = VENTILANDO;
        end
      end
      VENTILANDO: begin
        if (w_timeout || w_lleno_a) begin
          w_estado_sig = ALARMA;
        end else if (w_lleno_v) begin
          w_estado_sig = NORMAL;
        end
      end
      ALARMA: begin
        if (w_acepta) begin
          w_estado_sig = VENTILANDO;
        end
      end
      default: begin
        w_estado_sig = NORMAL;
      end
    endcase
  end

  assign Ventilacion = r_vent;
  assign Alarma      = r_alarma;
  assign Estado      = r_estado;

endmodule

// File: tb/tb_control_temp.sv
// Directed bench for control_temp: hand-computed expectations per step.
module tb_control_temp;

  logic       clk;
  logic       reset_n;
  logic [4:0] Temp;
  logic       Temp_valid;
  logic       Ack;
  logic       Ventilacion;
  logic       Alarma;
  logic [1:0] Estado;
  logic       Falla_sensor;

  int n_cmp = 0;
  int n_err = 0;

  control_temp #(
    .ANCHO         (5),
    .UMBRAL_VENT   (5'd20),
    .UMBRAL_ALARMA (5'd28),
    .HIST          (5'd2),
    .N_MUESTRAS    (3),
    .TIMEOUT       (16'd100)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .Temp         (Temp),
    .Temp_valid   (Temp_valid),
    .Ack          (Ack),
    .Ventilacion  (Ventilacion),
    .Alarma       (Alarma),
    .Estado       (Estado),
    .Falla_sensor (Falla_sensor)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic chk_sal(input string tag, input logic v, input logic a, input logic [1:0] e);
    chk({tag, ".vent"},   8'(Ventilacion), 8'(v));
    chk({tag, ".alarma"}, 8'(Alarma),      8'(a));
    chk({tag, ".estado"}, 8'(Estado),      8'(e));
  endtask

  // One clock: drive inputs, let the edge take them, settle, then idle inputs
  task automatic paso(input logic v, input logic [4:0] t, input logic a);
    Temp_valid = v;
    Temp       = t;
    Ack        = a;
    @(posedge clk);
    #1;
    Temp_valid = 1'b0;
    Ack        = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n    = 1'b0;
    Temp       = 5'd31;
    Temp_valid = 1'b0;
    Ack        = 1'b0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk_sal("reset", 1'b0, 1'b0, 2'd0);
    chk("reset.falla", 8'(Falla_sensor), 8'd0);
    reset_n = 1'b1;

    // NORMAL -> VENTILANDO after 3 strobes of 21
    paso(1'b1, 5'd21, 1'b0);
    paso(1'b1, 5'd21, 1'b0);
    chk_sal("vent.2of3", 1'b0, 1'b0, 2'd0);
    paso(1'b1, 5'd21, 1'b0);
    chk_sal("vent.3of3", 1'b1, 1'b0, 2'd1);

    // Hysteresis: 19 is not below 18 and breaks the run
    paso(1'b1, 5'd17, 1'b0);
    paso(1'b1, 5'd19, 1'b0);
    paso(1'b1, 5'd17, 1'b0);
    chk_sal("hist.hold", 1'b1, 1'b0, 2'd1);
    paso(1'b1, 5'd17, 1'b0);
    paso(1'b1, 5'd17, 1'b0);
    chk_sal("hist.back", 1'b0, 1'b0, 2'd0);
    paso(1'b1, 5'd17, 1'b0);
    chk_sal("hist.normal", 1'b0, 1'b0, 2'd0);

    // NORMAL -> ALARMA, alarm has priority over fan
    paso(1'b1, 5'd30, 1'b0);
    paso(1'b1, 5'd30, 1'b0);
    chk_sal("alm.2of3", 1'b0, 1'b0, 2'd0);
    paso(1'b1, 5'd30, 1'b0);
    chk_sal("alm.set", 1'b0, 1'b1, 2'd2);

    // Ack with last sample 30 or 27 is rejected
    paso(1'b0, 5'd0, 1'b1);
    chk("alm.ack30", 8'(Estado), 8'd2);
    paso(1'b1, 5'd27, 1'b0);
    paso(1'b0, 5'd0, 1'b1);
    chk_sal("alm.ack27", 1'b0, 1'b1, 2'd2);

    // Ack with a simultaneous strobe uses the new sample
    paso(1'b1, 5'd25, 1'b0);
    paso(1'b1, 5'd27, 1'b1);
    chk("alm.ack_new27", 8'(Estado), 8'd2);
    paso(1'b1, 5'd25, 1'b1);
    chk_sal("alm.ack25", 1'b1, 1'b0, 2'd1);

    // Ack outside ALARMA is ignored
    paso(1'b0, 5'd0, 1'b1);
    chk("ack.ignored", 8'(Estado), 8'd1);

    // Non-strobe cycles are ignored by the persistence filter
    do_reset();
    paso(1'b1, 5'd21, 1'b0);
    paso(1'b1, 5'd21, 1'b0);
    paso(1'b0, 5'd0, 1'b0);
    chk("gap.hold", 8'(Estado), 8'd0);
    paso(1'b1, 5'd21, 1'b0);
    chk_sal("gap.third", 1'b1, 1'b0, 2'd1);

    // Asynchronous reset clears outputs without a clock edge
    #2;
    reset_n = 1'b0;
    #1;
    chk_sal("areset", 1'b0, 1'b0, 2'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Reset mid-run discards partial persistence counts
    paso(1'b1, 5'd21, 1'b0);
    paso(1'b1, 5'd21, 1'b0);
    #2;
    reset_n = 1'b0;
    #2;
    chk_sal("mid.reset", 1'b0, 1'b0, 2'd0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    paso(1'b1, 5'd21, 1'b0);
    paso(1'b1, 5'd21, 1'b0);
    chk_sal("mid.2after", 1'b0, 1'b0, 2'd0);
    paso(1'b1, 5'd21, 1'b0);
    chk("mid.3after", 8'(Estado), 8'd1);

    // Threshold boundaries: 20 qualifies, 18 does not fall, 28 alarms, 26 blocks Ack
    do_reset();
    paso(1'b1, 5'd20, 1'b0);
    paso(1'b1, 5'd20, 1'b0);
    paso(1'b1, 5'd20, 1'b0);
    chk("edge.20", 8'(Estado), 8'd1);
    paso(1'b1, 5'd18, 1'b0);
    paso(1'b1, 5'd18, 1'b0);
    paso(1'b1, 5'd18, 1'b0);
    chk("edge.18", 8'(Estado), 8'd1);
    paso(1'b1, 5'd28, 1'b0);
    paso(1'b1, 5'd28, 1'b0);
    chk("edge.28x2", 8'(Estado), 8'd1);
    paso(1'b1, 5'd28, 1'b0);
    chk_sal("edge.28x3", 1'b0, 1'b1, 2'd2);
    paso(1'b1, 5'd26, 1'b1);
    chk("edge.ack26", 8'(Estado), 8'd2);

    // Sensor silence
    do_reset();
`ifdef SENSOR_TIMEOUT_EN
    repeat (95) paso(1'b0, 5'd0, 1'b0);
    chk("to.before", 8'(Falla_sensor), 8'd0);
    repeat (10) paso(1'b0, 5'd0, 1'b0);
    chk("to.falla", 8'(Falla_sensor), 8'd1);
    chk_sal("to.alarma", 1'b0, 1'b1, 2'd2);
    paso(1'b0, 5'd0, 1'b1);
    chk("to.ack_nosample", 8'(Falla_sensor), 8'd1);
    paso(1'b1, 5'd10, 1'b0);
    chk("to.sample", 8'(Estado), 8'd2);
    paso(1'b0, 5'd0, 1'b1);
    chk("to.cleared", 8'(Falla_sensor), 8'd0);
    chk_sal("to.vent", 1'b1, 1'b0, 2'd1);
`else
    repeat (120) paso(1'b0, 5'd0, 1'b0);
    chk("nto.falla", 8'(Falla_sensor), 8'd0);
    chk_sal("nto.normal", 1'b0, 1'b0, 2'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
